rom_arbiter: RTL
================

Name: rom_arbiter

Overview:
- Shares the single synchronous-read 8 KB ROM (8-bit data, 13-bit address, one-clock read latency) between two requesters: video fetch (port V) and CPU (port C).
- Fully pipelined: one ROM read is issued per clock, and results return in order with a tag.
- Port V has fixed priority. A starvation counter guarantees port C a slot.
- Sits between the requesters and the ROM wrapper, and drives the ROM address input.

Parameters:
- AW, 13, address width
- DW, 8, data width
- MAXWAIT, 4, consecutive cycles port C may be refused before it takes priority (≥1)

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- v_req  in  1  port V read request
- v_a    in  AW  port V address
- v_rdy  out  1  port V request accepted this cycle (combinational)
- v_ack  out  1  port V read data valid (one-cycle pulse)
- v_d    out  DW  port V read data
- c_req  in  1  port C read request
- c_a    in  AW  port C address
- c_rdy  out  1  port C request accepted this cycle (combinational)
- c_ack  out  1  port C read data valid (one-cycle pulse)
- c_d    out  DW  port C read data
- rom_a  out  AW  ROM address (registered)
- rom_d  in  DW  ROM data, valid one cycle after rom_a

Behaviour:
- Transfer: a transfer occurs in cycle T when req&&rdy. A requester holds its address stable until then, and may present a new address in T+1.
- Arbitration:
  - starve = (cwait == MAXWAIT)
  - v_rdy = v_req && !(c_req && starve)
  - c_rdy = c_req && (!v_req || starve)
  - At most one rdy is high per cycle. Both are forced 0 while reset is low.
- Starvation counter cwait (width clog2(MAXWAIT+1)):
  - +1 when c_req && !c_rdy, saturating at MAXWAIT.
  - Cleared to 0 when c_rdy, or when !c_req.
- Issue (edge ending T): rom_a <= granted address. If no grant, rom_a holds its value. Stage-1 tag <= {valid, port}.
- Stage 2 (edge ending T+1): the tag shifts to stage 2. The ROM presents data in T+2.
- Return (edge ending T+2): if the stage-2 tag is valid, the tagged port's x_d <= rom_d and x_ack <= 1. Otherwise both acks <= 0.
- Latency: ack is high in cycle T+3. Throughput is one read per clock. Results always return in issue order.
- x_d holds its value until that port's next ack. The other port's data is unaffected.
- Reset values: rom_a=0, v_d=0, c_d=0, v_ack=0, c_ack=0, cwait=0, all tags invalid.
- Reset mid-operation: in-flight reads are discarded, and no ack occurs after reset release for reads issued before reset.
- Simultaneous requests: V wins unless starve. In the starve cycle C wins, V is refused, and cwait clears.
- MAXWAIT=1: C is served on every second cycle under continuous V load.

Test Plan:
- Single C read: c_req=1, c_a=0x0005 for one cycle (c_rdy=1 at T) → rom_a=0x0005 in T+1; c_ack=1 and c_d=ROM[0x0005] in T+3 only; v_ack stays 0.
- Back-to-back V stream: v_req=1 with addresses 0x1000..0x1003 on consecutive cycles → v_rdy=1 each cycle; v_ack high T+3..T+6 with data ROM[0x1000..0x1003] in order.
- Contention with starvation, MAXWAIT=4: v_req held high, c_req high from T with c_a=0x0ABC →
  - c_rdy=0 in T..T+3 (cwait 1..4)
  - c_rdy=1 and v_rdy=0 in T+4
  - c_ack with ROM[0x0ABC] in T+7
  - V accepted again from T+5
- Interleave order: V@0x0010 at T, C@0x0020 at T+1 (V idle), V@0x0030 at T+2 → acks in T+3 (V), T+4 (C), T+5 (V); c_d holds ROM[0x0020] through T+5.
- Mid-flight reset: accept C@0x0001 at T, assert reset in T+1 for one cycle → no c_ack ever; rom_a=0, c_d=0, cwait=0 immediately at reset assertion.
- Counter clear: c_req refused for 2 cycles, then dropped for 1 cycle, then reasserted under V load → c_rdy first goes high 4 cycles after reassertion (the count restarted from 0).

Source files
------------

// File: rtl/rom_arbiter_if.sv
// Bus bundle between the two ROM requesters (video port V, CPU port C),
// the arbiter, and the synchronous-read ROM wrapper.
//
// Handshake: a request transfers in the cycle where x_req && x_rdy are both
// high. The requester holds x_a stable until that cycle and may present a new
// address in the next cycle. x_rdy is combinational from x_req. Read data
// comes back on x_d with a one-cycle x_ack pulse, three cycles after the
// transfer, in issue order.
interface rom_arbiter_if #(
  parameter int AW = 13,
  parameter int DW = 8
);
  logic          v_req;
  logic [AW-1:0] v_a;
  logic          v_rdy;
  logic          v_ack;
  logic [DW-1:0] v_d;

  logic          c_req;
  logic [AW-1:0] c_a;
  logic          c_rdy;
  logic          c_ack;
  logic [DW-1:0] c_d;

  logic [AW-1:0] rom_a;
  logic [DW-1:0] rom_d;

  // Arbiter side
  modport slave (
    input  v_req, v_a, c_req, c_a, rom_d,
    output v_rdy, v_ack, v_d, c_rdy, c_ack, c_d, rom_a
  );

  // Requester / ROM side
  modport master (
    output v_req, v_a, c_req, c_a, rom_d,
    input  v_rdy, v_ack, v_d, c_rdy, c_ack, c_d, rom_a
  );
endinterface

// File: rtl/rom_arbiter.sv
// Two-port fixed-priority arbiter for a single synchronous-read ROM.
// Port V wins every collision unless port C has been refused MAXWAIT
// consecutive cycles, in which case C takes that slot. One read issues per
// clock; a two-stage tag pipeline routes each returning byte to its port.
module rom_arbiter #(
  parameter int AW      = 13,
  parameter int DW      = 8,
  parameter int MAXWAIT = 4
) (
  input logic          clock,
  input logic          reset,
  rom_arbiter_if.slave bus
);

  localparam int            CW     = $clog2(MAXWAIT + 1);
  localparam logic [CW-1:0] CW_MAX = CW'(MAXWAIT);
  localparam logic          PORT_V = 1'b0;
  localparam logic          PORT_C = 1'b1;

  typedef struct packed {
    logic valid;
    logic port;
  } tag_t;

  logic [CW-1:0] cwait_q, cwait_d;
  logic [AW-1:0] rom_a_q, rom_a_d;
  tag_t          tag1_q,  tag1_d;
  tag_t          tag2_q,  tag2_d;
  logic [DW-1:0] v_d_q,   v_d_d;
  logic [DW-1:0] c_d_q,   c_d_d;
  logic          v_ack_q, v_ack_d;
  logic          c_ack_q, c_ack_d;

  logic starve;
  logic v_grant;
  logic c_grant;

  // Grant decision; both grants are held low while reset is asserted
  always_comb begin
    starve  = (cwait_q == CW_MAX);
    v_grant = reset && bus.v_req && !(bus.c_req && starve);
    c_grant = reset && bus.c_req && (!bus.v_req || starve);
  end

  // Starvation count: grows while C is refused, restarts when C is served or idle
  always_comb begin
    cwait_d = cwait_q;
    if (!bus.c_req || c_grant) begin
      cwait_d = '0;
    end else if (!starve) begin
      cwait_d = cwait_q + CW'(1);
    end
  end

  // Issue stage: latch the granted address and tag it with its port
  always_comb begin
    rom_a_d      = rom_a_q;
    tag1_d.valid = v_grant || c_grant;
    tag1_d.port  = c_grant ? PORT_C : PORT_V;
    if (v_grant) begin
      rom_a_d = bus.v_a;
    end else if (c_grant) begin
      rom_a_d = bus.c_a;
    end
    tag2_d = tag1_q;
  end

  // Return stage: steer ROM data to the tagged port, other port keeps its data
  always_comb begin
    v_ack_d = tag2_q.valid && (tag2_q.port == PORT_V);
    c_ack_d = tag2_q.valid && (tag2_q.port == PORT_C);
    v_d_d   = v_ack_d ? bus.rom_d : v_d_q;
    c_d_d   = c_ack_d ? bus.rom_d : c_d_q;
  end

  // State registers; reset drops every in-flight tag so no stale ack appears
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cwait_q <= '0;
      rom_a_q <= '0;
      tag1_q  <= '0;
      tag2_q  <= '0;
      v_d_q   <= '0;
      c_d_q   <= '0;
      v_ack_q <= 1'b0;
      c_ack_q <= 1'b0;
    end else begin
      cwait_q <= cwait_d;
      rom_a_q <= rom_a_d;
      tag1_q  <= tag1_d;
      tag2_q  <= tag2_d;
      v_d_q   <= v_d_d;
      c_d_q   <= c_d_d;
      v_ack_q <= v_ack_d;
      c_ack_q <= c_ack_d;
    end
  end

  // Output drive
  always_comb begin
    bus.v_rdy = v_grant;
    bus.c_rdy = c_grant;
    bus.rom_a = rom_a_q;
    bus.v_ack = v_ack_q;
    bus.c_ack = c_ack_q;
    bus.v_d   = v_d_q;
    bus.c_d   = c_d_q;
  end

endmodule
